// File: rtl/trng_bit_source.sv
// Entropy responder: synchronised ring-oscillator samples, von Neumann debiasing,
// a FIFO bit pool, and a one-bit registered output with LFSR fallback and a repetition health test.
module trng_bit_source #(
  parameter int          POOL_BITS  = 64,
  parameter int          SAMPLE_DIV = 4,
  parameter int          REP_LIMIT  = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         raw_noise,
  input  logic                         trng_req,
  output logic                         trng_bit,
  output logic [$clog2(POOL_BITS):0]   pool_level,
  output logic [15:0]                  underflow_cnt,
  output logic                         health_fail
);

  localparam int PW = $clog2(POOL_BITS);
  localparam int LW = PW + 1;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(POOL_BITS);
  localparam logic [7:0]    REP_MAX    = 8'(REP_LIMIT);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FRESH = 1'b1;

  logic          sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic          prev_q, prev_d;
  logic [7:0]    rep_q, rep_d;
  logic          fail_q, fail_d;
  logic          pair_full_q, pair_full_d;
  logic          first_q, first_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [0:0]    state_q, state_d;
  logic          bit_q, bit_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   unf_q, unf_d;

  logic pool_mem [POOL_BITS];

  logic sample_tick;
  logic push_req;
  logic push;
  logic pop;
  logic fallback;
  logic lfsr_fb;

  always_comb begin
    sample_tick = enable && (div_q == DIV_LAST);

    div_d = div_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    // Repetition count saturates so a long stuck run cannot wrap back below the limit.
    rep_d  = rep_q;
    prev_d = prev_q;
    if (sample_tick) begin
      prev_d = sync2_q;
      if (sync2_q == prev_q) begin
        rep_d = (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;
      end else begin
        rep_d = 8'd1;
      end
    end
    fail_d = fail_q | (sample_tick && (rep_d == REP_MAX));

    pair_full_d = pair_full_q;
    first_d     = first_q;
    if (!enable) begin
      pair_full_d = 1'b0;
    end else if (sample_tick) begin
      pair_full_d = !pair_full_q;
      if (!pair_full_q) begin
        first_d = sync2_q;
      end
    end

    // A differing pair pushes its first sample: 01 -> 0, 10 -> 1.
    push_req = sample_tick && pair_full_q && (first_q != sync2_q) && !fail_q;
    pop      = (level_q != '0) && ((state_q == ST_EMPTY) || trng_req);
    fallback = trng_req && (level_q == '0);
    push     = push_req && ((level_q != LEVEL_FULL) || pop);

    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop  ? rd_q + PW'(1) : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);

    lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d  = fallback ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
    unf_d   = (fallback && (unf_q != 16'hFFFF)) ? unf_q + 16'd1 : unf_q;

    bit_d   = bit_q;
    state_d = state_q;
    if (pop) begin
      bit_d   = pool_mem[rd_q];
      state_d = ST_FRESH;
    end else if (fallback) begin
      bit_d   = lfsr_q[0];
      state_d = ST_FRESH;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pool_mem[wr_q] <= first_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      div_q       <= '0;
      prev_q      <= 1'b0;
      rep_q       <= 8'd1;
      fail_q      <= 1'b0;
      pair_full_q <= 1'b0;
      first_q     <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      state_q     <= ST_EMPTY;
      bit_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      unf_q       <= '0;
    end else begin
      sync1_q     <= raw_noise;
      sync2_q     <= sync1_q;
      div_q       <= div_d;
      prev_q      <= prev_d;
      rep_q       <= rep_d;
      fail_q      <= fail_d;
      pair_full_q <= pair_full_d;
      first_q     <= first_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      level_q     <= level_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      lfsr_q      <= lfsr_d;
      unf_q       <= unf_d;
    end
  end

  assign trng_bit      = bit_q;
  assign pool_level    = level_q;
  assign underflow_cnt = unf_q;
  assign health_fail   = fail_q;

endmodule

// File: tb/tb_trng_bit_source.sv
// Directed bench for trng_bit_source: a queue-based reference model checked every cycle,
// plus literal expectations for reset, debias, serve, underflow, full-pool and health cases.
module tb_trng_bit_source;

  localparam int          POOL = 64;
  localparam int          SDIV = 1;
  localparam int          REP  = 32;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        raw_noise;
  logic        trng_req;
  logic        trng_bit;
  logic [6:0]  pool_level;
  logic [15:0] underflow_cnt;
  logic        health_fail;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;
  bit feed_q[$];

  trng_bit_source #(
    .POOL_BITS (POOL),
    .SAMPLE_DIV(SDIV),
    .REP_LIMIT (REP),
    .LFSR_SEED (SEED)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .raw_noise    (raw_noise),
    .trng_req     (trng_req),
    .trng_bit     (trng_bit),
    .pool_level   (pool_level),
    .underflow_cnt(underflow_cnt),
    .health_fail  (health_fail)
  );

  always #5 clk = ~clk;

  // Reference model: raw delay line, sample stream, FIFO queue, fallback bit stream.
  bit m_raw1, m_raw2;
  int m_div;
  bit m_prev;
  int m_rep;
  bit m_fail;
  bit m_pair_full, m_first;
  bit m_pool[$];
  bit m_bit, m_fresh;
  bit m_lfq[$];
  int m_unf;

  task automatic model_reset();
    m_raw1 = 0; m_raw2 = 0; m_div = 0; m_prev = 0; m_rep = 1; m_fail = 0;
    m_pair_full = 0; m_first = 0; m_pool.delete(); m_bit = 0; m_fresh = 0; m_unf = 0;
    m_lfq.delete();
    for (int i = 0; i < 16; i++) m_lfq.push_back(SEED[i]);
  endtask

  initial model_reset();

  always @(posedge clk or negedge resetn) begin : mdl
    bit s, old_fail, push, pbit;
    if (!resetn) begin
      model_reset();
    end else begin
      s = m_raw2; old_fail = m_fail; push = 0; pbit = 0;
      if (m_pool.size() > 0 && (!m_fresh || trng_req)) begin
        m_bit = m_pool.pop_front();
        m_fresh = 1;
      end else if (trng_req) begin
        // Output stream obeys s[n+16] = s[n] ^ s[n+2] ^ s[n+3] ^ s[n+5].
        m_lfq.push_back(m_lfq[0] ^ m_lfq[2] ^ m_lfq[3] ^ m_lfq[5]);
        m_bit = m_lfq.pop_front();
        if (m_unf < 65535) m_unf++;
        m_fresh = 1;
      end
      if (enable) begin
        if (m_div == SDIV - 1) begin
          if (s == m_prev) begin
            if (m_rep < 255) m_rep++;
          end else begin
            m_rep = 1;
          end
          if (m_rep == REP) m_fail = 1;
          m_prev = s;
          if (!m_pair_full) begin
            m_first = s; m_pair_full = 1;
          end else begin
            m_pair_full = 0;
            if (m_first != s && !old_fail) begin push = 1; pbit = m_first; end
          end
          m_div = 0;
        end else begin
          m_div++;
        end
      end else begin
        m_pair_full = 0;
      end
      if (push && m_pool.size() < POOL) m_pool.push_back(pbit);
      m_raw2 = m_raw1;
      m_raw1 = raw_noise;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model trng_bit", 32'(trng_bit), 32'(m_bit));
      chk("model pool_level", 32'(pool_level), 32'(m_pool.size()));
      chk("model underflow_cnt", 32'(underflow_cnt), 32'(m_unf));
      chk("model health_fail", 32'(health_fail), 32'(m_fail));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 0; enable = 0; trng_req = 0; raw_noise = 0;
    tick(); tick();
    resetn = 1;
    tick();
  endtask

  task automatic add_push(input bit d);
    feed_q.push_back(d);
    feed_q.push_back(!d);
  endtask

  // Sample k of feed_q is taken two clocks after it is driven; req_at pulses trng_req on one iteration.
  task automatic feed(input int req_at);
    int n;
    n = feed_q.size();
    for (int i = 0; i < n + 2; i++) begin
      raw_noise = (i < n) ? feed_q[i] : 1'b0;
      enable    = (i >= 2);
      trng_req  = (i == req_at);
      tick();
    end
    enable = 0; trng_req = 0;
    feed_q.delete();
  endtask

  initial begin
    logic [2:0] t3_bits;
    logic [4:0] t4_bits;
    bit         pat [65];

    resetn = 0; enable = 0; raw_noise = 0; trng_req = 0;
    tick(); tick();
    chk_en = 1;

    // T1: outputs stay cleared while reset is held
    enable = 1;
    for (int i = 0; i < 6; i++) begin
      raw_noise = ~raw_noise; trng_req = i[0];
      tick();
    end
    chk("T1 trng_bit", 32'(trng_bit), 32'd0);
    chk("T1 pool_level", 32'(pool_level), 32'd0);
    chk("T1 underflow_cnt", 32'(underflow_cnt), 32'd0);
    chk("T1 health_fail", 32'(health_fail), 32'd0);
    $display("T1 reset held: pool_level=%0d trng_bit=%0d", pool_level, trng_bit);
    resetn = 1; enable = 0; trng_req = 0; tick();

    // T2: 0,1,1,0,0,0,1,1 pushes 0 then 1; first push is preloaded into trng_bit
    do_reset();
    feed_q = '{0, 1, 1, 0, 0, 0, 1, 1};
    feed(-1);
    chk("T2 trng_bit", 32'(trng_bit), 32'd0);
    chk("T2 pool_level", 32'(pool_level), 32'd1);
    $display("T2 debias: trng_bit=%0d pool_level=%0d", trng_bit, pool_level);

    // T3: trng_bit=1 preloaded, pool 1,0,1 served over three request clocks
    do_reset();
    add_push(1); add_push(1); add_push(0); add_push(1);
    feed(-1);
    chk("T3 level before", 32'(pool_level), 32'd3);
    t3_bits = 3'b101;
    for (int i = 0; i < 3; i++) begin
      trng_req = 1; tick();
      chk("T3 served bit", 32'(trng_bit), 32'(t3_bits[2-i]));
      chk("T3 level", 32'(pool_level), 32'(2 - i));
      $display("T3 serve %0d: trng_bit=%0d pool_level=%0d", i, trng_bit, pool_level);
    end
    trng_req = 0; tick();
    chk("T3 underflow_cnt", 32'(underflow_cnt), 32'd0);

    // T4: empty pool serves the LFSR stream from 16'hACE1: 1,0,0,0,0
    do_reset();
    t4_bits = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      trng_req = 1; tick();
      chk("T4 lfsr bit", 32'(trng_bit), 32'(t4_bits[4-i]));
      $display("T4 underflow %0d: trng_bit=%0d underflow_cnt=%0d", i, trng_bit, underflow_cnt);
    end
    trng_req = 0; tick();
    chk("T4 underflow_cnt", 32'(underflow_cnt), 32'd5);

    // T5: 65 pushes fill trng_bit plus 64 pool entries; overflow drop; push+pop at full
    do_reset();
    for (int i = 0; i < 65; i++) pat[i] = (i % 3 == 1) ^ (i % 7 == 4);
    for (int i = 0; i < 65; i++) add_push(pat[i]);
    feed(-1);
    chk("T5 full level", 32'(pool_level), 32'd64);
    chk("T5 head preload", 32'(trng_bit), 32'(pat[0]));
    add_push(1);
    feed(-1);
    chk("T5 drop level", 32'(pool_level), 32'd64);
    $display("T5 full: pool_level=%0d after extra push", pool_level);
    add_push(0);
    feed(3);
    chk("T5 push+pop level", 32'(pool_level), 32'd64);
    chk("T5 push+pop bit", 32'(trng_bit), 32'(pat[1]));
    for (int i = 0; i < 64; i++) begin
      trng_req = 1; tick();
      if (i < 63) chk("T5 drain order", 32'(trng_bit), 32'(pat[i + 2]));
    end
    trng_req = 0; tick();
    chk("T5 drain last", 32'(trng_bit), 32'd0);
    chk("T5 drain level", 32'(pool_level), 32'd0);
    chk("T5 drain underflow", 32'(underflow_cnt), 32'd0);
    $display("T5 drained: trng_bit=%0d pool_level=%0d", trng_bit, pool_level);

    // T6: 31 identical samples pass, the 32nd trips; sticky until reset
    do_reset();
    for (int i = 0; i < 31; i++) feed_q.push_back(1'b1);
    feed(-1);
    chk("T6 below limit", 32'(health_fail), 32'd0);
    feed_q.push_back(1'b1);
    feed(-1);
    chk("T6 tripped", 32'(health_fail), 32'd1);
    add_push(0); add_push(1); add_push(0);
    feed(-1);
    chk("T6 frozen level", 32'(pool_level), 32'd0);
    chk("T6 sticky", 32'(health_fail), 32'd1);
    $display("T6 health: health_fail=%0d pool_level=%0d", health_fail, pool_level);
    do_reset();
    chk("T6 cleared", 32'(health_fail), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
